// File: rtl/sprite_overlay_engine.sv
// Movable, power-of-two scaled indexed-colour sprite overlay with a frame-synchronous show/blink FSM.
// Define SPRITE_TRANSP_EN to make palette index TRANSP_IDX transparent.
module sprite_overlay_engine #(
  parameter int unsigned SPR_W        = 80,
  parameter int unsigned SPR_H        = 45,
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned IDX_W        = 2,
  parameter int unsigned SCALE_LOG2   = 0,
  parameter int unsigned ROM_LAT      = 1,
  parameter int unsigned INIT_X       = 560,
  parameter int unsigned INIT_Y       = 434,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned TRANSP_IDX   = 0
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              pos_valid,
  output logic              pos_ready,
  input  logic              show,
  input  logic              blink,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_data,
  output logic              sprite_on,
  output logic [IDX_W-1:0]  pix_idx
);

  localparam int unsigned SW    = SPR_W << SCALE_LOG2;
  localparam int unsigned SH    = SPR_H << SCALE_LOG2;
  localparam int unsigned DLY   = ROM_LAT + 1;
  localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic [1:0] {S_HIDDEN, S_VISIBLE, S_BLINK_ON, S_BLINK_OFF} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [9:0]         act_x_q, act_x_d, act_y_q, act_y_d;
  logic [9:0]         pend_x_q, pend_x_d, pend_y_q, pend_y_d;
  logic               pos_ready_q, pos_ready_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic [DLY-1:0]     dl_q, dl_d;
  logic               sprite_on_q, sprite_on_d;
  logic [IDX_W-1:0]   pix_idx_q, pix_idx_d;

  logic               fs_c, vis_c, in_win_c, opaque_c;
  logic [10:0]        x_end_c, y_end_c;
  logic [9:0]         dx_c, dy_c;
  logic [ADDR_W-1:0]  addr_c;

  assign fs_c  = (DrawX == 10'd0) && (DrawY == 10'd0);
  assign vis_c = (state_q == S_VISIBLE) || (state_q == S_BLINK_ON);

  // Window bounds in 11 bits so a window near the right/bottom edge never wraps.
  assign x_end_c  = 11'(act_x_q) + 11'(SW);
  assign y_end_c  = 11'(act_y_q) + 11'(SH);
  assign in_win_c = (DrawX >= act_x_q) && (11'(DrawX) < x_end_c) &&
                    (DrawY >= act_y_q) && (11'(DrawY) < y_end_c) &&
                    (DrawX < 10'd640) && (DrawY < 10'd480);

  assign dx_c   = (DrawX - act_x_q) >> SCALE_LOG2;
  assign dy_c   = (DrawY - act_y_q) >> SCALE_LOG2;
  assign addr_c = ADDR_W'(dx_c) + ADDR_W'(dy_c) * ADDR_W'(SPR_W);

`ifdef SPRITE_TRANSP_EN
  assign opaque_c = (rom_data != IDX_W'(TRANSP_IDX));
`else
  logic unused_transp;
  assign opaque_c      = 1'b1;
  assign unused_transp = ^(IDX_W'(TRANSP_IDX));
`endif

  // Show/blink state machine; every transition is taken on a frame start only.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      state_q <= S_HIDDEN;
      cnt_q   <= '0;
    end else if (fs_c) begin
      if (!show) begin
        state_q <= S_HIDDEN;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          S_HIDDEN: begin
            state_q <= blink ? S_BLINK_ON : S_VISIBLE;
            cnt_q   <= '0;
          end
          S_VISIBLE: begin
            if (blink) begin
              state_q <= S_BLINK_ON;
              cnt_q   <= '0;
            end
          end
          S_BLINK_ON, S_BLINK_OFF: begin
            if (!blink) begin
              state_q <= S_VISIBLE;
              cnt_q   <= '0;
            end else if (cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
              state_q <= (state_q == S_BLINK_ON) ? S_BLINK_OFF : S_BLINK_ON;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_q <= S_HIDDEN;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  // Position handshake, address generation and the matched on/blank/visible delay line.
  always_comb begin
    act_x_d     = act_x_q;
    act_y_d     = act_y_q;
    pend_x_d    = pend_x_q;
    pend_y_d    = pend_y_q;
    pos_ready_d = pos_ready_q;
    rom_addr_d  = rom_addr_q;

    if (pos_valid && pos_ready_q) begin
      pend_x_d    = pos_x;
      pend_y_d    = pos_y;
      pos_ready_d = 1'b0;
    end
    // An empty pending slot (pos_ready high) means nothing to commit on this frame start.
    if (fs_c && !pos_ready_q) begin
      act_x_d     = pend_x_q;
      act_y_d     = pend_y_q;
      pos_ready_d = 1'b1;
    end
    if (in_win_c) begin
      rom_addr_d = addr_c;
    end

    dl_d        = {dl_q[DLY-2:0], in_win_c & blank & vis_c};
    sprite_on_d = dl_q[DLY-1] & opaque_c;
    pix_idx_d   = sprite_on_d ? rom_data : '0;
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      act_x_q     <= 10'(INIT_X);
      act_y_q     <= 10'(INIT_Y);
      pend_x_q    <= '0;
      pend_y_q    <= '0;
      pos_ready_q <= 1'b1;
      rom_addr_q  <= '0;
      dl_q        <= '0;
      sprite_on_q <= 1'b0;
      pix_idx_q   <= '0;
    end else begin
      act_x_q     <= act_x_d;
      act_y_q     <= act_y_d;
      pend_x_q    <= pend_x_d;
      pend_y_q    <= pend_y_d;
      pos_ready_q <= pos_ready_d;
      rom_addr_q  <= rom_addr_d;
      dl_q        <= dl_d;
      sprite_on_q <= sprite_on_d;
      pix_idx_q   <= pix_idx_d;
    end
  end

  assign pos_ready = pos_ready_q;
  assign rom_addr  = rom_addr_q;
  assign sprite_on = sprite_on_q;
  assign pix_idx   = pix_idx_q;

endmodule

// File: tb/tb_sprite_overlay_engine.sv
// Self-checking bench for sprite_overlay_engine: unscaled instance (u0) and 2x-scaled instance (u1).
module tb_sprite_overlay_engine;

  logic        vga_clk = 1'b0;
  logic        reset_n;
  logic [9:0]  DrawX, DrawY, pos_x, pos_y;
  logic        blank, pos_valid, show, blink;
  logic        pos_ready_a, pos_ready_b, sprite_on_a, sprite_on_b;
  logic [11:0] rom_addr_a, rom_addr_b;
  logic [1:0]  rom_data_a, rom_data_b, pix_idx_a, pix_idx_b;

`ifdef SPRITE_TRANSP_EN
  localparam bit TR = 1'b1;
`else
  localparam bit TR = 1'b0;
`endif

  always #5 vga_clk = ~vga_clk;

  sprite_overlay_engine #(.BLINK_FRAMES(2)) u0 (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .pos_x(pos_x), .pos_y(pos_y), .pos_valid(pos_valid), .pos_ready(pos_ready_a),
    .show(show), .blink(blink), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
    .sprite_on(sprite_on_a), .pix_idx(pix_idx_a));

  sprite_overlay_engine #(.SCALE_LOG2(1), .BLINK_FRAMES(2)) u1 (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .pos_x(pos_x), .pos_y(pos_y), .pos_valid(pos_valid), .pos_ready(pos_ready_b),
    .show(show), .blink(blink), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
    .sprite_on(sprite_on_b), .pix_idx(pix_idx_b));

  // Sprite ROM contents: word 5 is index 0, all others nonzero.
  function automatic logic [1:0] rom_f(input logic [11:0] a);
    if (a == 12'd5) return 2'd0;
    return 2'(a % 12'd3 + 12'd1);
  endfunction

  always @(posedge vga_clk) begin
    rom_data_a <= rom_f(rom_addr_a);
    rom_data_b <= rom_f(rom_addr_b);
  end

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  always @(posedge vga_clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input int tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s (tag %0d): got %0d, expected %0d", name, tag, act, exp);
    end
  endtask

  typedef struct { int due; bit sel; int addr; int tag; } addr_exp_t;
  typedef struct { int due; bit sel; bit on; int idx; int tag; } pix_exp_t;
  addr_exp_t aq[$];
  pix_exp_t  pq[$];

  // Scoreboard: pop every expectation that falls due on this cycle.
  always @(negedge vga_clk) begin : sb
    addr_exp_t ea;
    pix_exp_t  ep;
    while (aq.size() > 0 && aq[0].due == edge_cnt) begin
      ea = aq.pop_front();
      chk("rom_addr", ea.tag, ea.sel ? int'(rom_addr_b) : int'(rom_addr_a), ea.addr);
    end
    while (pq.size() > 0 && pq[0].due == edge_cnt) begin
      ep = pq.pop_front();
      chk("sprite_on", ep.tag, ep.sel ? int'(sprite_on_b) : int'(sprite_on_a), int'(ep.on));
      chk("pix_idx", ep.tag, ep.sel ? int'(pix_idx_b) : int'(pix_idx_a), ep.idx);
    end
  end

  // Drive one pixel; rom_addr is due one edge later, sprite_on/pix_idx two edges after that.
  task automatic px(input int x, input int y, input bit b, input bit sel, input bit ca,
                    input int ea, input bit cp, input bit eon, input int eidx, input int tag);
    @(negedge vga_clk);
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = b;
    if (ca) aq.push_back('{edge_cnt + 1, sel, ea, tag});
    if (cp) pq.push_back('{edge_cnt + 3, sel, eon, eidx, tag});
  endtask

  task automatic fs();
    px(0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) px(700, 500, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic probe(input int tag, input bit eon);
    px(100, 100, 1'b1, 1'b0, 1'b0, 0, 1'b1, eon, eon ? 1 : 0, tag);
  endtask

  typedef struct { int x; int y; bit b; bit sel; int ea; bit eon; int eidx; } vec_t;
  vec_t tab[$];

  task automatic run_tab(input int base);
    foreach (tab[i])
      px(tab[i].x, tab[i].y, tab[i].b, tab[i].sel, 1'b1, tab[i].ea, 1'b1,
         tab[i].eon, tab[i].eidx, base + i);
    tab.delete();
  endtask

  initial begin
    reset_n = 1'b0; show = 1'b1; blink = 1'b0; pos_valid = 1'b0;
    pos_x = '0; pos_y = '0; DrawX = 10'd700; DrawY = 10'd500; blank = 1'b0;
    idle(3);
    chk("rst_sprite_on", 1, int'(sprite_on_a), 0);
    chk("rst_pix_idx", 1, int'(pix_idx_a), 0);
    chk("rst_rom_addr", 1, int'(rom_addr_a), 0);
    chk("rst_pos_ready", 1, int'(pos_ready_a), 1);
    chk("rst_sprite_on", 2, int'(sprite_on_b), 0);
    chk("rst_pix_idx", 2, int'(pix_idx_b), 0);
    chk("rst_rom_addr", 2, int'(rom_addr_b), 0);
    chk("rst_pos_ready", 2, int'(pos_ready_b), 1);
    reset_n = 1'b1;

    // HIDDEN until the first frame start even with show held high.
    px(560, 434, 1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0, 0, 10);
    fs();
    tab.push_back('{560, 434, 1'b1, 1'b0, 0, 1'b1, 1});
    tab.push_back('{561, 434, 1'b1, 1'b0, 1, 1'b1, 2});
    tab.push_back('{639, 478, 1'b1, 1'b0, 3599, 1'b1, 3});
    tab.push_back('{559, 434, 1'b1, 1'b0, 3599, 1'b0, 0});
    tab.push_back('{560, 433, 1'b1, 1'b0, 3599, 1'b0, 0});
    tab.push_back('{640, 434, 1'b1, 1'b0, 3599, 1'b0, 0});
    tab.push_back('{560, 479, 1'b1, 1'b0, 3599, 1'b0, 0});
    tab.push_back('{564, 434, 1'b1, 1'b0, 4, 1'b1, 2});
    tab.push_back('{565, 434, 1'b1, 1'b0, 5, !TR, 0});
    tab.push_back('{566, 434, 1'b1, 1'b0, 6, 1'b1, 1});
    tab.push_back('{560, 434, 1'b0, 1'b0, 0, 1'b0, 0});
    tab.push_back('{561, 434, 1'b1, 1'b0, 1, 1'b1, 2});
    tab.push_back('{562, 434, 1'b0, 1'b0, 2, 1'b0, 0});
    tab.push_back('{563, 434, 1'b1, 1'b0, 3, 1'b1, 1});
    run_tab(100);

    // Mid-frame transfer: old position holds until the next frame start.
    px(560, 434, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1, 300);
    pos_x = 10'd200; pos_y = 10'd50; pos_valid = 1'b1;
    px(561, 434, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1, 2, 301);
    pos_valid = 1'b0;
    chk("pos_ready_low", 301, int'(pos_ready_a), 0);
    px(200, 50, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 0, 302);
    px(560, 434, 1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b1, 1, 303);
    chk("pos_ready_hold", 303, int'(pos_ready_a), 0);
    fs();
    chk("pos_ready_at_fs", 304, int'(pos_ready_a), 0);
    px(200, 50, 1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b1, 1, 305);
    chk("pos_ready_rise", 305, int'(pos_ready_a), 1);
    px(560, 434, 1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0, 0, 306);

    // Transfer on the frame-start cycle itself is deferred one frame.
    fs();
    pos_x = 10'd100; pos_y = 10'd100; pos_valid = 1'b1;
    px(200, 50, 1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b1, 1, 310);
    pos_valid = 1'b0;
    chk("pos_ready_fs_xfer", 310, int'(pos_ready_a), 0);
    px(100, 100, 1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0, 0, 311);
    px(201, 50, 1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b1, 2, 312);
    fs();
    chk("pos_ready_deferred", 313, int'(pos_ready_a), 0);
    px(100, 100, 1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b1, 1, 314);
    chk("pos_ready_rise2", 314, int'(pos_ready_a), 1);
    px(200, 50, 1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0, 0, 315);

    // 2x scaled instance at (100,100).
    tab.push_back('{100, 100, 1'b1, 1'b1, 0, 1'b1, 1});
    tab.push_back('{101, 100, 1'b1, 1'b1, 0, 1'b1, 1});
    tab.push_back('{100, 101, 1'b1, 1'b1, 0, 1'b1, 1});
    tab.push_back('{101, 101, 1'b1, 1'b1, 0, 1'b1, 1});
    tab.push_back('{102, 100, 1'b1, 1'b1, 1, 1'b1, 2});
    tab.push_back('{100, 102, 1'b1, 1'b1, 80, 1'b1, 3});
    tab.push_back('{259, 100, 1'b1, 1'b1, 79, 1'b1, 2});
    tab.push_back('{260, 100, 1'b1, 1'b1, 79, 1'b0, 0});
    tab.push_back('{100, 189, 1'b1, 1'b1, 3520, 1'b1, 2});
    tab.push_back('{100, 190, 1'b1, 1'b1, 3520, 1'b0, 0});
    run_tab(400);

    // Blink with two frames per half-period, then show dropped mid-frame.
    blink = 1'b1;
    fs(); probe(500, 1'b1);
    fs(); probe(501, 1'b1);
    fs(); probe(502, 1'b0);
    blink = 1'b0;
    probe(503, 1'b0);
    blink = 1'b1;
    fs(); probe(504, 1'b0);
    fs(); probe(505, 1'b1);
    fs(); probe(506, 1'b1);
    show = 1'b0;
    probe(507, 1'b1);
    fs(); probe(508, 1'b0);
    show = 1'b1; blink = 1'b0;
    fs(); probe(509, 1'b1);
    idle(4);

    // Reset asserted while a sprite pixel is being output.
    px(100, 100, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0);
    repeat (3) @(negedge vga_clk);
    chk("pre_rst_on", 600, int'(sprite_on_a), 1);
    chk("pre_rst_idx", 600, int'(pix_idx_a), 1);
    reset_n = 1'b0;
    @(negedge vga_clk);
    chk("mid_rst_on", 601, int'(sprite_on_a), 0);
    chk("mid_rst_idx", 601, int'(pix_idx_a), 0);
    chk("mid_rst_on_b", 601, int'(sprite_on_b), 0);
    reset_n = 1'b1;
    px(560, 434, 1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0, 0, 602);
    px(561, 434, 1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b0, 0, 603);
    fs();
    px(560, 434, 1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b1, 1, 604);
    px(100, 100, 1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0, 0, 605);
    chk("post_rst_ready", 605, int'(pos_ready_a), 1);
    idle(5);
    chk("sb_drain", 700, aq.size() + pq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_overlay_engine.md
Name: sprite_overlay_engine

Overview:
Parametrised successor to the fixed-position corner sprite overlays, such as the checkmate banner. It renders one W×H indexed-colour sprite at a runtime-movable position, with an integer power-of-two scale factor and a registered pipeline matched to a synchronous ROM. A frame-synchronous show/blink state machine drives it. Its pixel index and on flag feed the existing palette and pixel-mux logic in the HDMI piece controller.

Parameters:
SPR_W, 80, sprite width in source pixels
SPR_H, 45, sprite height in source pixels
ADDR_W, 12, ROM address width; must satisfy 2^ADDR_W >= SPR_W*SPR_H
IDX_W, 2, palette index width
SCALE_LOG2, 0, on-screen scale = 2^SCALE_LOG2 in both axes (0..3)
ROM_LAT, 1, ROM read latency in cycles (1 or 2)
INIT_X, 560, reset X position (left column, inclusive)
INIT_Y, 434, reset Y position (top row, inclusive)
BLINK_FRAMES, 30, frames per blink half-period (>=1)
TRANSP_IDX, 0, palette index treated as transparent (optional feature only)

Ports:
vga_clk  in  1  pixel clock, the only clock
reset_n  in  1  synchronous, active-low reset
DrawX  in  10  current pixel column
DrawY  in  10  current pixel row
blank  in  1  high = visible display area
pos_x  in  10  new sprite X
pos_y  in  10  new sprite Y
pos_valid  in  1  position update request
pos_ready  out  1  engine can accept a position update
show  in  1  level: sprite requested visible
blink  in  1  level: blink while shown
rom_addr  out  ADDR_W  registered sprite ROM address
rom_data  in  IDX_W  ROM output, valid ROM_LAT cycles after rom_addr
sprite_on  out  1  pixel belongs to the opaque sprite (pipelined)
pix_idx  out  IDX_W  palette index (pipelined)

Behaviour:
- One clock domain, vga_clk. reset_n is sampled only on rising edges and is active-low.
- Reset values:
  - sprite_on=0, pix_idx=0, rom_addr=0, pos_ready=1.
  - Active position = (INIT_X, INIT_Y); pending register cleared.
  - FSM in HIDDEN; frame counter = 0.
  - Pipeline valid/on bits cleared.
- A reset asserted mid-frame drops sprite_on to 0 on the following edge.
- Frame start (FS) is the cycle where DrawX==0 and DrawY==0. All FSM transitions and position commits happen only on FS.
- Window: SW = SPR_W<<SCALE_LOG2 and SH = SPR_H<<SCALE_LOG2.
  - in_win = X<=DrawX<X+SW and Y<=DrawY<Y+SH, with sums computed in 11 bits so there is no wrap.
  - Any part of the window beyond column 639 or row 479 is simply never drawn.
- Address: dx = (DrawX-X)>>SCALE_LOG2 and dy = (DrawY-Y)>>SCALE_LOG2. rom_addr = dx + dy*SPR_W, truncated to ADDR_W.
  - rom_addr is registered 1 cycle after sampling.
  - Outside the window, rom_addr holds its previous value.
- Latency: sprite_on and pix_idx reflect the DrawX/DrawY/blank sampled exactly ROM_LAT+1 edges earlier. in_win, blank and the FSM-visible bit travel in a matching delay line.
  - sprite_on = in_win_d & blank_d & vis_d.
  - pix_idx = rom_data when sprite_on is 1; otherwise 0.
- FSM (evaluated on FS):
  - Any state with show=0: go to HIDDEN.
  - HIDDEN with show=1: go to VISIBLE if blink=0, else BLINK_ON.
  - VISIBLE with blink=1: go to BLINK_ON.
  - BLINK_ON/BLINK_OFF with blink=0: go to VISIBLE.
  - BLINK_ON and BLINK_OFF toggle after BLINK_FRAMES frame starts in the current state; the frame counter clears on every state entry.
  - vis = 1 in VISIBLE and BLINK_ON only.
- Position handshake:
  - A transfer happens when pos_valid & pos_ready; pos_x/pos_y are captured into pending and pos_ready goes to 0 on the next cycle.
  - At the next FS, pending is copied to active and pos_ready returns to 1 on the following cycle.
  - A transfer on the same cycle as an FS is applied at the following FS, never the current one.
  - The active position never changes mid-frame.
- show and blink are sampled only at FS; glitches between frame starts are ignored.

Optional Feature:
SPRITE_TRANSP_EN.
- Defined: any pixel whose rom_data equals TRANSP_IDX forces sprite_on=0 and pix_idx=0, which lets sprites overlay board squares.
- Undefined: every in-window, visible, unblanked pixel is on regardless of index, and TRANSP_IDX is unused.

Test Plan:
- Reset with defaults and show=1 held (ROM_LAT=1):
  - Required: after the first FS, (DrawX=560, DrawY=434) produces rom_addr=0, then sprite_on=1 two edges after sampling.
  - Required: (639,478) gives rom_addr=79+44*80=3599.
  - Required: (559,434) and (560,433) give sprite_on=0.
- SCALE_LOG2=1, pos=(100,100) committed:
  - Required: pixels (100..101,100..101) all read rom_addr=0, and (102,100) reads addr 1.
  - Required: sprite_on=0 at DrawX=260 (=100+160).
- Position handshake:
  - Stimulus: pos_valid=1 with (200,50) mid-frame.
  - Required: pos_ready falls and the sprite remains at the old position for the rest of the frame; the new position takes effect from the next FS, where pos_ready rises.
  - Stimulus: repeat with the transfer on the FS cycle itself.
  - Required: the update is deferred by one frame.
- Blink with BLINK_FRAMES=2, show=1, blink=1:
  - Required: visible for 2 frames, hidden for 2, visible for 2.
  - Required: dropping show mid-frame hides the sprite only from the next FS.
- blank=0 inside the window, and reset_n=0 asserted mid-sprite:
  - Required: sprite_on=0 aligned to the pipeline for blank=0; sprite_on=0 on the next edge after reset.
  - Required: after reset the FSM is in HIDDEN and the position is back to (INIT_X, INIT_Y).
- With SPRITE_TRANSP_EN and a ROM word equal to 0 at addr 5:
  - Required: sprite_on=0 at that pixel while its neighbours are on.
  - Required: without the macro, the same pixel is on with pix_idx=0.
